multicycle_core: RTL and testbench
==================================

MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width (minimum 32).
REQ-002 Parameter ADDR_W, default 11, word-address width of both memory ports.
REQ-003 Parameter RESET_PC, default 0, byte address loaded into PC at reset.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset: one clock; asynchronous, active-low.
REQ-006 start  in  1  level; leaves IDLE when high.
REQ-007 imem_addr  out  ADDR_W  instruction word address (PC[ADDR_W+1:2]).
REQ-008 imem_rdata  in  32  instruction, valid one cycle after imem_addr (synchronous memory).
REQ-009 dmem_req  out  1  data access request.
REQ-010 dmem_we  out  1  write when high with dmem_req.
REQ-011 dmem_addr  out  ADDR_W  data word address (effective address [ADDR_W+1:2]).
REQ-012 dmem_wdata  out  DATA_W  store data.
REQ-013 dmem_rdata  in  DATA_W  load data, sampled in the dmem_ack cycle.
REQ-014 dmem_ack  in  1  access complete; any latency of 1 or more cycles.
REQ-015 flags  out  4  NZCV.
REQ-016 halted  out  1  high in HALT.
REQ-017 dbg_sel  in  4 / dbg_data  out  DATA_W  combinational register-file read port.

Function
REQ-018 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-019 Transitions: IDLE->FETCH on start; FETCH->DECODE; DECODE->EXEC; EXEC->WB/MEM/FETCH/HALT by class; MEM->WB (LDR) or FETCH (STR) on dmem_ack; WB->FETCH.
REQ-020 Fetch: FETCH drives imem_addr; DECODE latches imem_rdata into IR; PC+=4 in DECODE.
REQ-021 Decode fields: cond[31:28], op[27:26], I[25], cmd[24:21], S[20], Rn[19:16], Rd[15:12].
REQ-022 Data processing (op=00): AND 0000, SUB 0010, ADD 0100, ORR 1100, MOV 1101, CMP 1010.
- operand2 = I ? zero-extended imm8 : Rm[3:0].
- Any other cmd is a NOP.
REQ-023 Flag update when S=1 (CMP always sets flags, never writes Rd).
- N = result MSB; Z = result==0.
- C = carry-out (ADD) or NOT borrow (SUB/CMP).
- V = signed overflow.
- AND/ORR/MOV clear C and V.
REQ-024 Memory (op=01), no writeback of base.
- L[20] selects LDR/STR; U[23] selects add/subtract of imm12 to Rn.
- dmem_req rises the cycle after EXEC and is held stable with addr/we/wdata until dmem_ack; dropped the cycle after ack.
REQ-025 Branch (op=10): target = PC_instr + 8 + (sign-extended imm24 << 2); PC updated in EXEC, 3 cycles total.
REQ-026 Condition: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL (0000-1110).
- A failed condition goes EXEC->FETCH with no side effects.
REQ-027 cond=1111 enters HALT, held until reset.
REQ-028 Register reads of R15 return PC_instr+8; register-file writes to R15 are ignored.
REQ-029 Cycle counts: DP 4, branch 3, STR 4+wait, LDR 5+wait, where wait = cycles dmem_ack is low.
REQ-030 Arithmetic is modulo 2^DATA_W; imm8 and imm12 are zero-extended to DATA_W.

Reset
REQ-031 On rst low: state=IDLE, PC=RESET_PC, IR=0, all registers 0, flags=0, dmem_req=0, dmem_we=0, halted=0, regardless of state (including mid-MEM).
REQ-032 All outputs assume their reset values asynchronously; leaving reset takes effect on the first clk edge after rst goes high.

Structure
REQ-033 Package core_pkg holds the state enum, ALU-operation enum, cmd/op/cond constants and NZCV field indices.
REQ-034 One sub-module, core_alu: combinational, parameter DATA_W, outputs result and NZCV.

Verification
REQ-035 Reset, start, MOV R1,#5 then ADDS R2,R1,#3 -> R2=8, flags=0000, ADD completes 4 cycles after its FETCH.
REQ-036 R1=5, SUBS R0,R1,#5 then ADDNE R3,R3,#1 -> flags Z=1,C=1; R3 unchanged; no dmem_req.
REQ-037 STR R1,[R0,#8] with R0=0, ack delayed 3 cycles -> dmem_addr=2, wdata=5, we=1, req stable 4 cycles; LDR R4,[R0,#8] -> R4=5.
REQ-038 B with imm24=0xFFFFFE at PC=0x10 -> next fetch at 0x10; cond=1111 word -> halted=1 permanently.
REQ-039 rst low during MEM with ack withheld -> dmem_req=0 immediately, state IDLE, all registers 0.
REQ-040 ADDS 0x7FFFFFFF + 1 -> result 0x80000000, N=1, V=1, C=0, Z=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and encodings for the multicycle core: FSM states, ALU operations,
// instruction field constants, condition evaluation and NZCV bit positions.
package core_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StHalt
   } state_e;

   typedef enum logic [2:0] {
      AluAnd,
      AluSub,
      AluAdd,
      AluOrr,
      AluMov
   } alu_op_e;

   // Instruction class, bits [27:26]
   localparam logic [1:0] OpDp  = 2'b00;
   localparam logic [1:0] OpMem = 2'b01;
   localparam logic [1:0] OpBr  = 2'b10;

   // Data-processing commands, bits [24:21]
   localparam logic [3:0] CmdAnd = 4'b0000;
   localparam logic [3:0] CmdSub = 4'b0010;
   localparam logic [3:0] CmdAdd = 4'b0100;
   localparam logic [3:0] CmdCmp = 4'b1010;
   localparam logic [3:0] CmdOrr = 4'b1100;
   localparam logic [3:0] CmdMov = 4'b1101;

   // Condition codes, bits [31:28]
   localparam logic [3:0] CondEq = 4'b0000;
   localparam logic [3:0] CondNe = 4'b0001;
   localparam logic [3:0] CondCs = 4'b0010;
   localparam logic [3:0] CondCc = 4'b0011;
   localparam logic [3:0] CondMi = 4'b0100;
   localparam logic [3:0] CondPl = 4'b0101;
   localparam logic [3:0] CondVs = 4'b0110;
   localparam logic [3:0] CondVc = 4'b0111;
   localparam logic [3:0] CondHi = 4'b1000;
   localparam logic [3:0] CondLs = 4'b1001;
   localparam logic [3:0] CondGe = 4'b1010;
   localparam logic [3:0] CondLt = 4'b1011;
   localparam logic [3:0] CondGt = 4'b1100;
   localparam logic [3:0] CondLe = 4'b1101;
   localparam logic [3:0] CondAl = 4'b1110;
   localparam logic [3:0] CondNv = 4'b1111;

   // NZCV bit positions within the 4-bit flags vector
   localparam int unsigned FlagN = 3;
   localparam int unsigned FlagZ = 2;
   localparam int unsigned FlagC = 1;
   localparam int unsigned FlagV = 0;

   // True when the condition field passes against the current flags; NV never passes
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, pass;
      n = nzcv[FlagN];
      z = nzcv[FlagZ];
      c = nzcv[FlagC];
      v = nzcv[FlagV];
      pass = 1'b0;
      case (cond)
         CondEq:  pass = z;
         CondNe:  pass = !z;
         CondCs:  pass = c;
         CondCc:  pass = !c;
         CondMi:  pass = n;
         CondPl:  pass = !n;
         CondVs:  pass = v;
         CondVc:  pass = !v;
         CondHi:  pass = c && !z;
         CondLs:  pass = !c || z;
         CondGe:  pass = (n == v);
         CondLt:  pass = (n != v);
         CondGt:  pass = !z && (n == v);
         CondLe:  pass = z || (n != v);
         CondAl:  pass = 1'b1;
         default: pass = 1'b0;
      endcase
      return pass;
   endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU: AND/SUB/ADD/ORR/MOV with NZCV. Logical ops clear C and V;
// for subtraction C is NOT borrow.
module core_alu
   import core_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  alu_op_e           op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] result_o,
   output logic [3:0]        nzcv_o
);

   logic [DATA_W:0] sum;
   logic            carry;
   logic            ovf;

   // Result and flag generation
   always_comb begin
      sum      = '0;
      result_o = '0;
      carry    = 1'b0;
      ovf      = 1'b0;
      case (op_i)
         AluAdd: begin
            sum      = {1'b0, a_i} + {1'b0, b_i};
            result_o = sum[DATA_W-1:0];
            carry    = sum[DATA_W];
            ovf      = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (result_o[DATA_W-1] != a_i[DATA_W-1]);
         end
         AluSub: begin
            sum      = {1'b0, a_i} - {1'b0, b_i};
            result_o = sum[DATA_W-1:0];
            carry    = !sum[DATA_W];
            ovf      = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (result_o[DATA_W-1] != a_i[DATA_W-1]);
         end
         AluAnd:  result_o = a_i & b_i;
         AluOrr:  result_o = a_i | b_i;
         AluMov:  result_o = b_i;
         default: result_o = '0;
      endcase
      nzcv_o = {result_o[DATA_W-1], (result_o == '0), carry, ovf};
   end

endmodule

// File: rtl/multicycle_core.sv
// Multicycle ARM-like core: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with a
// synchronous instruction port, a req/ack data port and a 16-entry register file.
module multicycle_core
   import core_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 11,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic [31:0]       imem_rdata_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [DATA_W-1:0] dmem_wdata_o,
   input  logic [DATA_W-1:0] dmem_rdata_i,
   input  logic              dmem_ack_i,
   output logic [3:0]        flags_o,
   output logic              halted_o,
   input  logic [3:0]        dbg_sel_i,
   output logic [DATA_W-1:0] dbg_data_o
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [3:0]        flags_q, flags_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              wb_en_q, wb_en_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rf_q [16];
   logic              rf_we;

   // Instruction fields
   logic [3:0] cond, cmd, rn, rd, rm;
   logic [1:0] op;
   logic       imm_bit, s_bit, u_bit;
   assign cond    = ir_q[31:28];
   assign op      = ir_q[27:26];
   assign imm_bit = ir_q[25];
   assign cmd     = ir_q[24:21];
   assign u_bit   = ir_q[23];
   assign s_bit   = ir_q[20];
   assign rn      = ir_q[19:16];
   assign rd      = ir_q[15:12];
   assign rm      = ir_q[3:0];

   // pc_q already holds PC_instr+4 once DECODE is done, so R15 reads see PC_instr+8
   logic [DATA_W-1:0] pc_plus8, rn_val, rm_val, rd_val, op2, imm12, ea, br_off;
   assign pc_plus8 = pc_q + DATA_W'(4);
   assign rn_val   = (rn == 4'hF) ? pc_plus8 : rf_q[rn];
   assign rm_val   = (rm == 4'hF) ? pc_plus8 : rf_q[rm];
   assign rd_val   = (rd == 4'hF) ? pc_plus8 : rf_q[rd];
   assign op2      = imm_bit ? {{(DATA_W-8){1'b0}}, ir_q[7:0]} : rm_val;
   assign imm12    = {{(DATA_W-12){1'b0}}, ir_q[11:0]};
   assign ea       = u_bit ? (rn_val + imm12) : (rn_val - imm12);
   assign br_off   = {{(DATA_W-26){ir_q[23]}}, ir_q[23:0], 2'b00};

   // Only the word-address slice of the effective address reaches the port
   logic unused_ea;
   assign unused_ea = ^{ea[DATA_W-1:ADDR_W+2], ea[1:0]};

   alu_op_e           alu_op;
   logic              dp_valid;
   logic [DATA_W-1:0] alu_res;
   logic [3:0]        alu_nzcv;

   // Map data-processing command to ALU operation; unknown commands are NOPs
   always_comb begin
      alu_op   = AluAnd;
      dp_valid = 1'b1;
      case (cmd)
         CmdAnd:  alu_op = AluAnd;
         CmdSub:  alu_op = AluSub;
         CmdAdd:  alu_op = AluAdd;
         CmdOrr:  alu_op = AluOrr;
         CmdMov:  alu_op = AluMov;
         CmdCmp:  alu_op = AluSub;
         default: dp_valid = 1'b0;
      endcase
   end

   core_alu #(
      .DATA_W(DATA_W)
   ) u_alu (
      .op_i    (alu_op),
      .a_i     (rn_val),
      .b_i     (op2),
      .result_o(alu_res),
      .nzcv_o  (alu_nzcv)
   );

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      flags_d = flags_q;
      res_d   = res_q;
      wb_en_d = wb_en_q;
      req_d   = req_q;
      we_d    = we_q;
      maddr_d = maddr_q;
      wdata_d = wdata_q;
      rf_we   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start_i) state_d = StFetch;
         end
         StFetch: state_d = StDecode;
         StDecode: begin
            ir_d    = imem_rdata_i;
            pc_d    = pc_q + DATA_W'(4);
            state_d = StExec;
         end
         StExec: begin
            wb_en_d = 1'b0;
            if (cond == CondNv) begin
               state_d = StHalt;
            end else if (!cond_pass(cond, flags_q)) begin
               state_d = StFetch;
            end else begin
               case (op)
                  OpDp: begin
                     state_d = StWb;
                     if (dp_valid) begin
                        res_d   = alu_res;
                        wb_en_d = (cmd != CmdCmp);
                        if (s_bit || (cmd == CmdCmp)) flags_d = alu_nzcv;
                     end
                  end
                  OpMem: begin
                     req_d   = 1'b1;
                     we_d    = !s_bit;
                     maddr_d = ea[ADDR_W+1:2];
                     wdata_d = rd_val;
                     wb_en_d = s_bit;
                     state_d = StMem;
                  end
                  OpBr: begin
                     pc_d    = pc_plus8 + br_off;
                     state_d = StFetch;
                  end
                  default: state_d = StFetch;
               endcase
            end
         end
         StMem: begin
            if (dmem_ack_i) begin
               req_d = 1'b0;
               we_d  = 1'b0;
               if (we_q) begin
                  state_d = StFetch;
               end else begin
                  res_d   = dmem_rdata_i;
                  state_d = StWb;
               end
            end
         end
         StWb: begin
            rf_we   = wb_en_q;
            state_d = StFetch;
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   // State, datapath and register-file registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         pc_q    <= DATA_W'(RESET_PC);
         ir_q    <= '0;
         flags_q <= '0;
         res_q   <= '0;
         wb_en_q <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         maddr_q <= '0;
         wdata_q <= '0;
         for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         flags_q <= flags_d;
         res_q   <= res_d;
         wb_en_q <= wb_en_d;
         req_q   <= req_d;
         we_q    <= we_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
         if (rf_we && (rd != 4'hF)) rf_q[rd] <= res_q;
      end
   end

   assign imem_addr_o  = pc_q[ADDR_W+1:2];
   assign dmem_req_o   = req_q;
   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = maddr_q;
   assign dmem_wdata_o = wdata_q;
   assign flags_o      = flags_q;
   assign halted_o     = (state_q == StHalt);
   // Selector 15 shows the live PC since R15 has no storage of its own
   assign dbg_data_o   = (dbg_sel_i == 4'hF) ? pc_q : rf_q[dbg_sel_i];

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: single-instruction vector table plus
// hand-written sequences for timing, memory handshake, branch, halt and reset.
module tb_multicycle_core;

   localparam int AW = 11;
   localparam logic [31:0] HALT_W = 32'hF000_0000;

   logic          clk = 1'b0;
   logic          rst_n, start;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata;
   logic          dmem_req, dmem_we, dmem_ack;
   logic [AW-1:0] dmem_addr;
   logic [31:0]   dmem_wdata, dmem_rdata;
   logic [3:0]    flags, dbg_sel;
   logic          halted;
   logic [31:0]   dbg_data;

   logic [31:0] imem [0:2047];
   logic [31:0] dmem [0:2047];

   always #5 clk = ~clk;

   // Synchronous instruction memory
   always @(posedge clk) imem_rdata <= imem[imem_addr];

   multicycle_core #(
      .DATA_W  (32),
      .ADDR_W  (AW),
      .RESET_PC(0)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .imem_addr_o (imem_addr),
      .imem_rdata_i(imem_rdata),
      .dmem_req_o  (dmem_req),
      .dmem_we_o   (dmem_we),
      .dmem_addr_o (dmem_addr),
      .dmem_wdata_o(dmem_wdata),
      .dmem_rdata_i(dmem_rdata),
      .dmem_ack_i  (dmem_ack),
      .flags_o     (flags),
      .halted_o    (halted),
      .dbg_sel_i   (dbg_sel),
      .dbg_data_o  (dbg_data)
   );

   int checks = 0;
   int errors = 0;
   int ch_q[$];
   logic [AW-1:0] ia_q[$];
   int req_len_q[$];
   logic [AW-1:0] cap_addr_q[$];
   logic [31:0] cap_wdata_q[$];
   logic cap_we_q[$];
   int stable_err;
   int req_cycles;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dp(input logic [3:0] cond, input logic i, input logic [3:0] cmd,
                                      input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                      input logic [11:0] op2);
      return {cond, 2'b00, i, cmd, s, rn, rd, op2};
   endfunction

   function automatic logic [31:0] mem(input logic l, input logic u, input logic [3:0] rn,
                                       input logic [3:0] rd, input logic [11:0] imm);
      return {4'hE, 2'b01, 1'b0, 1'b1, u, 2'b00, l, rn, rd, imm};
   endfunction

   function automatic logic [31:0] br(input logic [3:0] cond, input logic [23:0] imm24);
      return {cond, 2'b10, 2'b00, imm24};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 2048; i++) begin
         imem[i] = HALT_W;
         dmem[i] = '0;
      end
   endtask

   task automatic rdreg(input int r, output logic [31:0] v);
      dbg_sel = r[3:0];
      #1;
      v = dbg_data;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      start    = 1'b0;
      dmem_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ch_q.delete();
      ia_q.delete();
      req_len_q.delete();
      cap_addr_q.delete();
      cap_wdata_q.delete();
      cap_we_q.delete();
      stable_err = 0;
      req_cycles = 0;
   endtask

   // Reset, start, and clock until HALT or budget; models data memory with ack_dly low cycles
   task automatic run(input int max_cyc, input int ack_dly, input bit expect_halt);
      int cyc = 0;
      int wait_cnt = 0;
      int rlen = 0;
      logic [AW-1:0] last_ia;
      do_reset();
      last_ia = imem_addr;
      start = 1'b1;
      while (cyc < max_cyc && !halted) begin
         @(negedge clk);
         cyc++;
         if (imem_addr !== last_ia) begin
            ch_q.push_back(cyc);
            ia_q.push_back(imem_addr);
            last_ia = imem_addr;
         end
         if (dmem_req) begin
            req_cycles++;
            if (rlen == 0) begin
               cap_addr_q.push_back(dmem_addr);
               cap_wdata_q.push_back(dmem_wdata);
               cap_we_q.push_back(dmem_we);
            end else if (dmem_addr !== cap_addr_q[$] || dmem_wdata !== cap_wdata_q[$] ||
                         dmem_we !== cap_we_q[$]) begin
               stable_err++;
            end
            rlen++;
            dmem_rdata = dmem[dmem_addr];
            if (wait_cnt == ack_dly) begin
               dmem_ack = 1'b1;
               if (dmem_we) dmem[dmem_addr] = dmem_wdata;
               req_len_q.push_back(rlen);
               rlen = 0;
               wait_cnt = 0;
            end else begin
               dmem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            dmem_ack = 1'b0;
         end
      end
      if (expect_halt) check("halt_reached", {31'b0, halted}, 32'd1);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] instr;
      int          rchk;
      logic [31:0] exp_val;
      logic [3:0]  exp_flags;
   } vec_t;

   vec_t vecs [17];

   initial begin
      logic [31:0] v;
      int n;
      rst_n      = 1'b0;
      start      = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      dbg_sel    = '0;
      clear_mem();

      // Each vector: R1=a, R2=b loaded from dmem, then instr at byte 8, then HALT
      vecs[0]  = '{32'h7FFF_FFFF, 32'h1, dp(4'hE, 0, 4'h4, 1, 1, 3, 12'h002), 3, 32'h8000_0000, 4'b1001};
      vecs[1]  = '{32'hFFFF_FFFF, 32'h1, dp(4'hE, 0, 4'h4, 1, 1, 3, 12'h002), 3, 32'h0, 4'b0110};
      vecs[2]  = '{32'h5, 32'h5, dp(4'hE, 0, 4'h2, 1, 1, 3, 12'h002), 3, 32'h0, 4'b0110};
      vecs[3]  = '{32'h3, 32'h5, dp(4'hE, 0, 4'h2, 1, 1, 3, 12'h002), 3, 32'hFFFF_FFFE, 4'b1000};
      vecs[4]  = '{32'h8000_0000, 32'h1, dp(4'hE, 0, 4'h2, 1, 1, 3, 12'h002), 3, 32'h7FFF_FFFF, 4'b0011};
      vecs[5]  = '{32'hF0F0_00FF, 32'h0FF0_0F0F, dp(4'hE, 0, 4'h0, 1, 1, 3, 12'h002), 3, 32'h00F0_000F, 4'b0000};
      vecs[6]  = '{32'h8000_0000, 32'h1, dp(4'hE, 0, 4'hC, 1, 1, 3, 12'h002), 3, 32'h8000_0001, 4'b1000};
      vecs[7]  = '{32'h9, 32'h9, dp(4'hE, 1, 4'hD, 1, 0, 3, 12'h000), 3, 32'h0, 4'b0100};
      vecs[8]  = '{32'h5, 32'h7, dp(4'hE, 0, 4'hA, 0, 1, 3, 12'h002), 3, 32'h0, 4'b1000};
      vecs[9]  = '{32'h100, 32'h0, dp(4'hE, 1, 4'h4, 0, 1, 3, 12'h0FF), 3, 32'h1FF, 4'b0000};
      vecs[10] = '{32'h5, 32'h7, dp(4'hE, 0, 4'h1, 1, 1, 3, 12'h002), 3, 32'h0, 4'b0000};
      vecs[11] = '{32'h0, 32'h0, dp(4'hE, 0, 4'hD, 0, 0, 3, 12'h00F), 3, 32'h10, 4'b0000};
      vecs[12] = '{32'h0, 32'h1, dp(4'hE, 0, 4'h2, 0, 1, 3, 12'h002), 3, 32'hFFFF_FFFF, 4'b0000};
      vecs[13] = '{32'h2, 32'h3, dp(4'h0, 0, 4'h4, 0, 1, 3, 12'h002), 3, 32'h0, 4'b0000};
      vecs[14] = '{32'h2, 32'h3, dp(4'h3, 0, 4'h4, 0, 1, 3, 12'h002), 3, 32'h5, 4'b0000};
      vecs[15] = '{32'h2, 32'h3, dp(4'hB, 0, 4'h4, 0, 1, 3, 12'h002), 3, 32'h0, 4'b0000};
      vecs[16] = '{32'h1, 32'h8000_0000, dp(4'hE, 0, 4'hD, 1, 1, 3, 12'h002), 3, 32'h8000_0000, 4'b1000};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req", {31'b0, dmem_req}, 32'd0);
      check("rst_we", {31'b0, dmem_we}, 32'd0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_flags", {28'b0, flags}, 32'd0);
      check("rst_imem_addr", {21'b0, imem_addr}, 32'd0);
      for (int r = 0; r < 15; r++) begin
         rdreg(r, v);
         check($sformatf("rst_r%0d", r), v, 32'd0);
      end
      rst_n = 1'b1;

      // Vector table
      for (int i = 0; i < 17; i++) begin
         clear_mem();
         imem[0] = mem(1, 1, 0, 1, 12'h000);
         imem[1] = mem(1, 1, 0, 2, 12'h004);
         imem[2] = vecs[i].instr;
         dmem[0] = vecs[i].a;
         dmem[1] = vecs[i].b;
         run(200, i % 3, 1);
         rdreg(vecs[i].rchk, v);
         check($sformatf("vec%0d_val", i), v, vecs[i].exp_val);
         check($sformatf("vec%0d_flags", i), {28'b0, flags}, {28'b0, vecs[i].exp_flags});
      end

      // MOV R1,#5 ; ADDS R2,R1,#3 : result, flags and 4-cycle spacing
      clear_mem();
      imem[0] = dp(4'hE, 1, 4'hD, 0, 0, 1, 12'h005);
      imem[1] = dp(4'hE, 1, 4'h4, 1, 1, 2, 12'h003);
      run(100, 0, 1);
      rdreg(2, v);
      check("a_r2", v, 32'd8);
      check("a_flags", {28'b0, flags}, 32'd0);
      n = ch_q.size();
      check("a_nchg", n, 32'd3);
      if (n >= 3) begin
         check("a_mov_cycles", ch_q[1] - ch_q[0], 32'd4);
         check("a_add_cycles", ch_q[2] - ch_q[1], 32'd4);
      end

      // SUBS sets Z,C ; ADDNE skipped in 3 cycles ; ADDEQ executes
      clear_mem();
      imem[0] = dp(4'hE, 1, 4'hD, 0, 0, 1, 12'h005);
      imem[1] = dp(4'hE, 1, 4'h2, 1, 1, 0, 12'h005);
      imem[2] = dp(4'h1, 1, 4'h4, 0, 3, 3, 12'h001);
      imem[3] = dp(4'h0, 1, 4'h4, 0, 4, 4, 12'h001);
      run(100, 0, 1);
      check("b_flags", {28'b0, flags}, 32'b0110);
      rdreg(0, v);
      check("b_r0", v, 32'd0);
      rdreg(3, v);
      check("b_r3", v, 32'd0);
      rdreg(4, v);
      check("b_r4", v, 32'd1);
      check("b_no_req", req_cycles, 32'd0);
      n = ch_q.size();
      check("b_nchg", n, 32'd5);
      if (n >= 5) begin
         check("b_skip_cycles", ch_q[3] - ch_q[2], 32'd3);
         check("b_addeq_cycles", ch_q[4] - ch_q[3], 32'd4);
      end

      // STR/LDR with ack held off 3 cycles; LDR with subtracted offset
      clear_mem();
      imem[0] = dp(4'hE, 1, 4'hD, 0, 0, 1, 12'h005);
      imem[1] = dp(4'hE, 1, 4'hD, 0, 0, 0, 12'h000);
      imem[2] = mem(0, 1, 0, 1, 12'h008);
      imem[3] = mem(1, 1, 0, 4, 12'h008);
      imem[4] = mem(1, 0, 1, 5, 12'h001);
      dmem[1] = 32'hCAFE_0001;
      run(200, 3, 1);
      n = req_len_q.size();
      check("c_ntxn", n, 32'd3);
      if (n >= 3) begin
         check("c_str_req_len", req_len_q[0], 32'd4);
         check("c_str_addr", {21'b0, cap_addr_q[0]}, 32'd2);
         check("c_str_wdata", cap_wdata_q[0], 32'd5);
         check("c_str_we", {31'b0, cap_we_q[0]}, 32'd1);
         check("c_ldr_we", {31'b0, cap_we_q[1]}, 32'd0);
         check("c_ldr_sub_addr", {21'b0, cap_addr_q[2]}, 32'd1);
      end
      check("c_stable", stable_err, 32'd0);
      check("c_dmem2", dmem[2], 32'd5);
      rdreg(4, v);
      check("c_r4", v, 32'd5);
      rdreg(5, v);
      check("c_r5", v, 32'hCAFE_0001);
      n = ch_q.size();
      check("c_nchg", n, 32'd6);
      if (n >= 6) begin
         check("c_str_cycles", ch_q[3] - ch_q[2], 32'd7);
         check("c_ldr_cycles", ch_q[4] - ch_q[3], 32'd8);
      end

      // Branch to self at 0x10
      clear_mem();
      for (int i = 0; i < 4; i++) imem[i] = dp(4'hE, 1, 4'hD, 0, 0, 1, 12'h001);
      imem[4] = br(4'hE, 24'hFFFFFE);
      run(40, 0, 0);
      check("d_not_halted", {31'b0, halted}, 32'd0);
      n = ch_q.size();
      check("d_nchg_min", {31'b0, (n >= 7)}, 32'd1);
      if (n >= 7) begin
         check("d_after_decode", {21'b0, ia_q[4]}, 32'd5);
         check("d_target", {21'b0, ia_q[5]}, 32'd4);
         check("d_br_cycles", ch_q[6] - ch_q[4], 32'd3);
      end

      // HALT is sticky while start stays high
      clear_mem();
      imem[0] = dp(4'hE, 1, 4'hD, 0, 0, 1, 12'h007);
      run(50, 0, 1);
      repeat (20) @(negedge clk);
      check("e_halted_hold", {31'b0, halted}, 32'd1);
      check("e_pc_hold", {21'b0, imem_addr}, 32'd2);
      rdreg(1, v);
      check("e_r1", v, 32'd7);

      // Asynchronous reset while a store waits for ack
      clear_mem();
      imem[0] = dp(4'hE, 1, 4'hD, 0, 0, 1, 12'h005);
      imem[1] = dp(4'hE, 1, 4'hD, 0, 0, 2, 12'h009);
      imem[2] = mem(0, 1, 0, 1, 12'h000);
      do_reset();
      start = 1'b1;
      n = 0;
      while (!dmem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("f_req_seen", {31'b0, dmem_req}, 32'd1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("f_req_async", {31'b0, dmem_req}, 32'd0);
      check("f_we_async", {31'b0, dmem_we}, 32'd0);
      check("f_flags_async", {28'b0, flags}, 32'd0);
      check("f_pc_async", {21'b0, imem_addr}, 32'd0);
      rdreg(1, v);
      check("f_r1", v, 32'd0);
      rdreg(2, v);
      check("f_r2", v, 32'd0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("f_idle_pc", {21'b0, imem_addr}, 32'd0);
      check("f_idle_req", {31'b0, dmem_req}, 32'd0);
      check("f_idle_halted", {31'b0, halted}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
